// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Baugh-Wooley / Wallace-tree multiplier with tag, valid and global stall
module wallace_mult_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int P = 2 * WIDTH;

  function automatic int rows_at(input int lvl);
    int r = WIDTH;
    for (int k = 0; k < lvl; k++) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int num_levels(input int w);
    int r = w;
    int n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      n++;
    end
    return n;
  endfunction

  localparam int L   = num_levels(WIDTH);
  localparam int LAT = (L + REG_EVERY - 1) / REG_EVERY + 1;

  typedef logic [P-1:0] row_t;
  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic [TAG_W-1:0] tag;
  } meta_t;

  meta_t meta_d [LAT];
  meta_t meta_q [LAT];
  row_t  pp [WIDTH];
  logic  adv;
  logic [P-1:0] p_d, p_q;

  assign adv       = !meta_q[LAT-1].vld | out_ready;
  assign in_ready  = adv;
  assign out_valid = meta_q[LAT-1].vld;
  assign out_tag   = meta_q[LAT-1].tag;
  assign p         = p_q;

  // Modified Baugh-Wooley: invert the mixed-sign terms and fold the +2^W and +2^(2W-1) corrections into row 0
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (a[j] & b[i]) ^ (is_signed & ((i == WIDTH-1) ^ (j == WIDTH-1)));
    end
    pp[0][WIDTH] = is_signed;
    pp[0][P-1]   = is_signed;
  end

  always_comb begin
    meta_d[0] = adv ? meta_t'({in_valid, is_signed, in_tag}) : meta_q[0];
    for (int s = 1; s < LAT; s++) meta_d[s] = adv ? meta_q[s-1] : meta_q[s];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int s = 0; s < LAT; s++) meta_q[s] <= '0;
    else        for (int s = 0; s < LAT; s++) meta_q[s] <= meta_d[s];

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int N = rows_at(l);
    localparam int G = N / 3;
    row_t src [WIDTH];
    row_t lo  [WIDTH];
    row_t out [WIDTH];
    if (l == 0) begin : g_src
      always_comb for (int i = 0; i < WIDTH; i++) src[i] = pp[i];
    end else begin : g_src
      always_comb for (int i = 0; i < WIDTH; i++) src[i] = g_lvl[l-1].out[i];
    end
    // Full adders on each row triple; leftover rows shift down unchanged
    always_comb begin
      for (int i = 0; i < WIDTH; i++) lo[i] = '0;
      for (int g = 0; g < G; g++) begin
        lo[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
        lo[2*g+1] = ((src[3*g] & src[3*g+1]) | (src[3*g] & src[3*g+2]) | (src[3*g+1] & src[3*g+2])) << 1;
      end
      for (int k = 3 * G; k < N; k++) lo[k-G] = src[k];
    end
    if (((l + 1) % REG_EVERY == 0) || (l == L - 1)) begin : g_reg
      row_t rd [WIDTH];
      row_t rq [WIDTH];
      always_comb for (int i = 0; i < WIDTH; i++) rd[i] = adv ? lo[i] : rq[i];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < WIDTH; i++) rq[i] <= '0;
        else        for (int i = 0; i < WIDTH; i++) rq[i] <= rd[i];
      always_comb for (int i = 0; i < WIDTH; i++) out[i] = rq[i];
    end else begin : g_wire
      always_comb for (int i = 0; i < WIDTH; i++) out[i] = lo[i];
    end
  end

  always_comb p_d = adv ? g_lvl[L-1].out[0] + g_lvl[L-1].out[1] : p_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: scoreboard bench for the default 32-bit pipe plus a WIDTH/REG_EVERY sweep
module tb_wallace_mult_pipe;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [63:0] p;
  logic [3:0]  out_tag;

  logic        sv = 0;
  logic [15:0] sa = '0;
  logic [15:0] sb = '0;
  logic        ss = 0;
  logic [3:0]  stag = '0;
  logic        sweep_done = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bp = 0;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  tag;
    int          acc;
    logic        chk;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wallace_mult_pipe #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .out_tag(out_tag));

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    logic [63:0] ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, want);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                      input logic [3:0] tt, input logic [63:0] ep);
    int n = 0;
    in_valid = 1; a = ta; b = tbv; is_signed = ts; in_tag = tt;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck at 0, required 1");
    end else q.push_back('{ep, tt, cyc, !bp});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out p=%h tag=%0d, required no output", p, out_tag);
      end else begin
        mon_e = q.pop_front();
        if (p !== mon_e.p || out_tag !== mon_e.tag || (mon_e.chk && cyc - mon_e.acc != 9)) begin
          errors++;
          $display("FAIL result got p=%h tag=%0d lat=%0d required p=%h tag=%0d lat=9",
                   p, out_tag, cyc - mon_e.acc, mon_e.p, mon_e.tag);
        end
      end
    end

  for (genvar c = 0; c < 6; c++) begin : g_cfg
    localparam int W = (c < 2) ? 4 : (c < 4) ? 8 : 16;
    localparam int R = c % 2 + 1;
    localparam int LATE = (W == 4) ? (R == 1 ? 3 : 2) : (W == 8) ? (R == 1 ? 5 : 3) : (R == 1 ? 7 : 4);
    logic             ir, ov;
    logic [2*W-1:0]   pw, ew;
    logic [3:0]       ot;
    logic [W-1:0]     aw, bw;
    logic [2*W-1:0]   ae, be;
    logic [2*W-1:0]   qp[$];
    logic [3:0]       qt[$];
    int               qa[$];
    logic [2*W-1:0]   fp;
    logic [3:0]       ft;
    int               fa;

    wallace_mult_pipe #(.WIDTH(W), .REG_EVERY(R), .TAG_W(4)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(ir),
      .a(sa[W-1:0]), .b(sb[W-1:0]), .is_signed(ss), .in_tag(stag),
      .out_valid(ov), .out_ready(1'b1), .p(pw), .out_tag(ot));

    always @(negedge clk)
      if (rst_n) begin
        if (sv) begin
          aw = sa[W-1:0];
          bw = sb[W-1:0];
          ae = ss ? {{W{aw[W-1]}}, aw} : {{W{1'b0}}, aw};
          be = ss ? {{W{bw[W-1]}}, bw} : {{W{1'b0}}, bw};
          ew = ae * be;
          checks++;
          if (!ir) begin
            errors++;
            $display("FAIL sweep_ready W=%0d R=%0d got 0 required 1", W, R);
          end else begin
            qp.push_back(ew); qt.push_back(stag); qa.push_back(cyc);
          end
        end
        if (ov) begin
          checks++;
          if (qp.size() == 0) begin
            errors++;
            $display("FAIL sweep_unexpected W=%0d R=%0d p=%h", W, R, pw);
          end else begin
            fp = qp.pop_front(); ft = qt.pop_front(); fa = qa.pop_front();
            if (pw !== fp || ot !== ft || cyc - fa != LATE) begin
              errors++;
              $display("FAIL sweep W=%0d R=%0d got p=%h tag=%0d lat=%0d required p=%h tag=%0d lat=%0d",
                       W, R, pw, ot, cyc - fa, fp, ft, LATE);
            end
          end
        end
      end

    initial begin
      wait (sweep_done);
      checks++;
      if (qp.size() != 0) begin
        errors++;
        $display("FAIL sweep_pending W=%0d R=%0d got %0d required 0", W, R, qp.size());
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] hold_p;
    logic [3:0]  hold_t;
    #2 rst_n = 0;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_p", p, 64'd0);
    chk("reset_out_tag", {60'd0, out_tag}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'd3, 64'hFFFFFFFE00000001);
    send(32'hFFFFFFFF, 32'h00000005, 1, 4'd5, 64'hFFFFFFFFFFFFFFFB);
    send(32'hFFFFFFFF, 32'h00000005, 0, 4'd6, 64'h00000004FFFFFFFB);
    send(32'h80000000, 32'h80000000, 1, 4'd7, 64'h4000000000000000);
    send(32'h7FFFFFFF, 32'h80000000, 1, 4'd8, 64'hC000000080000000);
    send(32'h7FFFFFFF, 32'h80000000, 0, 4'd9, 64'h3FFFFFFF80000000);
    send(32'h00000000, 32'hFFFFFFFF, 1, 4'd10, 64'h0000000000000000);
    send(32'h12345678, 32'h00000010, 0, 4'd11, 64'h0000000123456780);
    drain();

    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 4'(i), ref32(ra, rb, rs));
    end
    drain();

    bp = 1;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 4'(i + 3), ref32(ra, rb, rs));
    end
    out_ready = 0;
    chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
    hold_p = p; hold_t = out_tag;
    in_valid = 1; a = 32'hDEADBEEF; b = 32'h3; in_tag = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_p_stable", p, hold_p);
      chk("bp_tag_stable", {60'd0, out_tag}, {60'd0, hold_t});
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    drain();
    bp = 0;

    for (int i = 0; i < 4; i++) send(32'(i + 2), 32'h11, 0, 4'(i), ref32(32'(i + 2), 32'h11, 0));
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pre_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_p", p, 64'd0);
    chk("rst_mid_tag", {60'd0, out_tag}, 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_rel_ready", {63'd0, in_ready}, 64'd1);
    repeat (15) @(posedge clk);
    #1;
    send(32'h00000003, 32'h00000007, 1, 4'd12, 64'h0000000000000015);
    send(32'hFFFFFFFE, 32'hFFFFFFFD, 1, 4'd13, 64'h0000000000000006);
    drain();

    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 256; x++) begin
        ss = 1'(m); sa = 16'(x % 16); sb = 16'(x / 16); stag = 4'(x); sv = 1;
        @(posedge clk); #1;
      end
    for (int i = 0; i < 200; i++) begin
      ss = 1'($urandom_range(0, 1)); sa = 16'($urandom); sb = 16'($urandom); stag = 4'(i); sv = 1;
      @(posedge clk); #1;
    end
    sv = 0;
    repeat (20) @(posedge clk);
    sweep_done = 1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 4..64.
REQ-002 Parameter REG_EVERY, default 1: number of 3:2 CSA reduction levels between pipeline registers; legal range 1..4.
REQ-003 Parameter TAG_W, default 4: width of the user tag carried alongside each operation.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 in_valid  input  1: an operand pair is presented.
REQ-007 in_ready  output  1: block accepts the operand pair this cycle.
REQ-008 a  input  WIDTH: multiplicand.
REQ-009 b  input  WIDTH: multiplier.
REQ-010 is_signed  input  1: 1 selects a two's-complement product, 0 an unsigned product; sampled per transaction.
REQ-011 in_tag  input  TAG_W: user tag returned with the result.
REQ-012 out_valid  output  1: a result is presented.
REQ-013 out_ready  input  1: the consumer accepts the result this cycle.
REQ-014 p  output  2*WIDTH: product.
REQ-015 out_tag  output  TAG_W: tag of the transaction on p.

Function
REQ-016 Partial products: WIDTH rows of 2*WIDTH bits; signed mode uses Baugh-Wooley sign/correction bits so the result is exact with no separate negation.
REQ-017 Reduction: 3:2 CSA tree, Wallace grouping; leftover rows pass unchanged to the next level; continue until 2 rows remain; level count L(WIDTH): 32→8, 16→6, 8→4, 4→2.
REQ-018 Pipeline registers after every REG_EVERY reduction levels and after the last level; the final 2*WIDTH carry-propagate adder is registered once more.
REQ-019 Latency LAT = ceil(L/REG_EVERY) + 1 cycles from the accept cycle to out_valid, absent stalls; WIDTH=32, REG_EVERY=1 gives 9; WIDTH=8, REG_EVERY=2 gives 3.
REQ-020 Each stage holds a valid bit; is_signed and in_tag travel with the data in every stage.
REQ-021 Advance condition: adv = !out_valid | out_ready; when adv=1 all stages shift one place; when adv=0 all stages hold (global stall).
REQ-022 in_ready = adv, combinational; a transfer occurs when in_valid & in_ready.
REQ-023 A cycle with adv=1 and no input transfer inserts a bubble (valid=0) into stage 1.
REQ-024 p and out_tag remain stable while out_valid=1 and out_ready=0.
REQ-025 Arithmetic is exact modulo 2^(2*WIDTH); no overflow or saturation; the final-adder carry-out is discarded.
REQ-026 Results are delivered in acceptance order; throughput is 1 result per cycle with out_ready held high.
REQ-027 No combinational path from a, b, or in_valid to any output; in_ready depends only on out_valid and out_ready.

Reset
REQ-028 rst_n=0 clears all stage valid bits immediately (asynchronously): out_valid=0, p=0, out_tag=0.
REQ-029 Reset mid-operation discards every in-flight transaction; none reappears after release.
REQ-030 In the first cycle after rst_n rises, in_ready=1.

Verification
REQ-031 WIDTH=32, unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, tag=3 -> after 9 cycles, p=0xFFFFFFFE00000001, out_tag=3.
REQ-032 WIDTH=32, signed: a=0xFFFFFFFF (-1), b=0x00000005 -> p=0xFFFFFFFFFFFFFFFB; same operands with is_signed=0 -> p=0x00000004FFFFFFFB.
REQ-033 Back-to-back: 100 random pairs, one per cycle, out_ready=1 -> 100 results in order, no gaps, each matching the reference product and tag.
REQ-034 Backpressure: out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, p/out_tag stable; after release, no loss or duplication.
REQ-035 Reset mid-stream: rst_n pulsed low with 4 transactions in flight -> out_valid=0 at once; after release only new transactions emerge.
REQ-036 Parameter sweep: WIDTH∈{4,8,16}, REG_EVERY∈{1,2} -> latency matches REQ-019; exhaustive check for WIDTH=4 in both modes.
